// File: rtl/tb_gpio_stim_gen_pkg.sv
// Shared encodings and LFSR helper for the GPIO stimulus generator.
// Imported by the top and by every channel instance.
package tb_gpio_stim_gen_pkg;

  typedef enum logic [1:0] {
    STIM_HOLD   = 2'd0,
    STIM_TOGGLE = 2'd1,
    STIM_RANDOM = 2'd2,
    STIM_PULSE  = 2'd3
  } mode_t;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEF_SEED = 32'h0000_0001;

  // One right-shifting Galois step
  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/tb_stim_chan.sv
// One stimulus channel: mode FSM, period counter, pin and busy.
// A write always beats a same-cycle expiry.
module tb_stim_chan
  import tb_gpio_stim_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 16,
  parameter logic        RST_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                we,
  input  mode_t               cfg_mode,
  input  logic                cfg_level,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                rnd,
  output logic                pin,
  output logic                busy
);

  mode_t               state;
  mode_t               state_nx;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                level_q;
  logic                pin_q;
  logic                run;
  logic                expiry;
  logic                fire;

  // Counting runs only in the timed modes while enabled
  always_comb begin
    run    = en && (state != STIM_HOLD);
    expiry = (cnt_q == period_q);
    fire   = run && expiry && !we;
  end

  // Mode state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STIM_HOLD;
    else        state <= state_nx;
  end

  // Next mode: writes load, a finished pulse falls back to HOLD
  always_comb begin
    state_nx = state;
    if (we)
      state_nx = cfg_mode;
    else if (fire && state == STIM_PULSE)
      state_nx = STIM_HOLD;
  end

  // Period, counter, level and pin datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      level_q  <= RST_LEVEL;
      pin_q    <= RST_LEVEL;
    end else if (we) begin
      period_q <= cfg_period;
      cnt_q    <= '0;
      level_q  <= cfg_level;
      if (cfg_mode == STIM_HOLD ||
          cfg_mode == STIM_PULSE)
        pin_q <= cfg_level;
    end else if (run) begin
      if (expiry) cnt_q <= '0;
      else        cnt_q <= cnt_q + 1'b1;
      if (fire) begin
        unique case (state)
          STIM_TOGGLE: pin_q <= ~pin_q;
          STIM_RANDOM: pin_q <= rnd;
          STIM_PULSE: begin
            pin_q   <= ~level_q;
            level_q <= ~level_q;
          end
          default: pin_q <= pin_q;
        endcase
      end
    end
  end

  // Outputs: busy is exactly "mode register holds PULSE"
  always_comb begin
    pin  = pin_q;
    busy = (state == STIM_PULSE);
  end

endmodule

// File: rtl/tb_gpio_stim_gen.sv
// GPIO stimulus generator top: shared LFSR, write decode, channels.
// Each channel picks its own LFSR bit for RANDOM mode.
module tb_gpio_stim_gen
  import tb_gpio_stim_gen_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PERIOD_W  = 16,
  parameter logic [31:0] LFSR_SEED = LFSR_DEF_SEED,
  parameter logic        RST_LEVEL = 1'b1,
  localparam int unsigned CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                stim_en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_level,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NUM_CH-1:0]   gpio_pin,
  output logic [NUM_CH-1:0]   pulse_busy
);

  localparam logic [31:0] SEED =
    (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [31:0] lfsr;

  // Shared LFSR, frozen whenever the generator is disabled
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   lfsr <= SEED;
    else if (stim_en) lfsr <= lfsr_step(lfsr);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = cfg_we && (32'(cfg_ch) == c);

    tb_stim_chan #(
      .PERIOD_W  (PERIOD_W),
      .RST_LEVEL (RST_LEVEL)
    ) u_chan (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .en         (stim_en),
      .we         (hit),
      .cfg_mode   (mode_t'(cfg_mode)),
      .cfg_level  (cfg_level),
      .cfg_period (cfg_period),
      .rnd        (lfsr[c % 32]),
      .pin        (gpio_pin[c]),
      .busy       (pulse_busy[c])
    );
  end

endmodule

// File: tb/tb_tb_gpio_stim_gen.sv
// Scoreboard bench for the GPIO stimulus generator.
// Three channels so that cfg_ch has an out-of-range code.
module tb_tb_gpio_stim_gen;

  logic        clk;
  logic        rst_n;
  logic        stim_en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic        cfg_level;
  logic [15:0] cfg_period;
  logic [2:0]  gpio_pin;
  logic [2:0]  pulse_busy;

  tb_gpio_stim_gen #(
    .NUM_CH    (3),
    .PERIOD_W  (16),
    .LFSR_SEED (32'h1),
    .RST_LEVEL (1'b1)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .stim_en    (stim_en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_level  (cfg_level),
    .cfg_period (cfg_period),
    .gpio_pin   (gpio_pin),
    .pulse_busy (pulse_busy)
  );

  typedef struct {
    int          cyc;
    bit          kind;
    string       name;
    logic [2:0]  pin;
    logic [2:0]  busy;
    logic [31:0] lfsr;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] ref_lfsr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference LFSR
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 32'h1;
    else if (stim_en) begin
      if (ref_lfsr[0])
        ref_lfsr <= {1'b0, ref_lfsr[31:1]} ^ 32'h8020_0003;
      else
        ref_lfsr <= {1'b0, ref_lfsr[31:1]};
    end
  end

  // Monitor: pop every expectation due this cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s late: due cyc %0d seen at %0d",
                 e.name, e.cyc, cyc);
      end else if (e.kind) begin
        if (dut.lfsr !== e.lfsr) begin
          n_bad++;
          $display("FAIL %s cyc=%0d lfsr=%h expected %h",
                   e.name, cyc, dut.lfsr, e.lfsr);
        end
      end else if (gpio_pin !== e.pin ||
                   pulse_busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s cyc=%0d pin=%b busy=%b expected pin=%b busy=%b",
                 e.name, cyc, gpio_pin, pulse_busy, e.pin, e.busy);
      end
    end
  end

  task automatic push(input exp_t e);
    int i;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic chk(input int d, input string nm,
                     input logic [2:0] p, input logic [2:0] b);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = 1'b0;
    e.name = nm;
    e.pin  = p;
    e.busy = b;
    e.lfsr = '0;
    push(e);
  endtask

  task automatic lchk(input int d, input string nm,
                      input logic [31:0] l);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = 1'b1;
    e.name = nm;
    e.pin  = '0;
    e.busy = '0;
    e.lfsr = l;
    push(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Write lands on the next edge; returns just after that edge
  task automatic wr(input logic [1:0] ch, input logic [1:0] m,
                    input logic l, input logic [15:0] p);
    cfg_ch     = ch;
    cfg_mode   = m;
    cfg_level  = l;
    cfg_period = p;
    cfg_we     = 1'b1;
    tick();
    cfg_we     = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          guard;
    rst_n      = 1'b1;
    stim_en    = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_level  = 1'b0;
    cfg_period = '0;
    #2 rst_n = 1'b0;

    tick();
    chk(0, "reset", 3'b111, 3'b000);
    tick();
    chk(0, "reset", 3'b111, 3'b000);
    rst_n   = 1'b1;
    stim_en = 1'b1;
    for (int d = 1; d <= 3; d++)
      chk(d, "post_reset", 3'b111, 3'b000);
    ticks(3);

    // Out-of-range channel
    wr(2'd3, 2'd3, 1'b0, 16'd2);
    for (int d = 0; d < 5; d++)
      chk(d, "bad_ch", 3'b111, 3'b000);
    ticks(4);

    // TOGGLE ch0, period 3
    wr(2'd0, 2'd1, 1'b0, 16'd3);
    for (int d = 0; d < 16; d++)
      chk(d, "toggle", {2'b11, ((d / 4) % 2) == 0}, 3'b000);
    ticks(16);

    // Rewrite landing on an expiry edge
    ticks(3);
    wr(2'd0, 2'd1, 1'b0, 16'd3);
    for (int d = 0; d <= 8; d++)
      chk(d, "collide", {2'b11, ((d / 4) % 2) == 0}, 3'b000);
    ticks(8);

    wr(2'd0, 2'd0, 1'b1, 16'd0);
    chk(0, "hold0", 3'b111, 3'b000);

    // PULSE ch1, level 0, period 9
    wr(2'd1, 2'd3, 1'b0, 16'd9);
    for (int d = 0; d < 14; d++)
      chk(d, "pulse",
          (d < 10) ? 3'b101 : 3'b111,
          (d < 10) ? 3'b010 : 3'b000);
    ticks(13);

    // PULSE with a 5-cycle enable gap
    wr(2'd1, 2'd3, 1'b0, 16'd9);
    for (int d = 0; d < 18; d++)
      chk(d, "pulse_gap",
          (d < 15) ? 3'b101 : 3'b111,
          (d < 15) ? 3'b010 : 3'b000);
    ticks(3);
    stim_en = 1'b0;
    lchk(5, "lfsr_gap", ref_lfsr);
    ticks(5);
    stim_en = 1'b1;
    ticks(9);

    // RANDOM on ch0 and ch1, period 0
    wr(2'd0, 2'd2, 1'b0, 16'd0);
    wr(2'd1, 2'd2, 1'b0, 16'd0);
    for (int i = 0; i < 1000; i++) begin
      r = ref_lfsr;
      tick();
      chk(0, "random", {1'b1, r[1:0]}, 3'b000);
    end

    // Reset in the middle of a pulse
    wr(2'd0, 2'd0, 1'b1, 16'd0);
    wr(2'd1, 2'd0, 1'b1, 16'd0);
    chk(0, "hold_all", 3'b111, 3'b000);
    wr(2'd1, 2'd3, 1'b0, 16'd9);
    ticks(3);
    chk(0, "pre_reset", 3'b101, 3'b010);
    tick();
    rst_n = 1'b0;
    chk(0, "reset_mid", 3'b111, 3'b000);
    ticks(2);
    rst_n = 1'b1;
    for (int d = 1; d <= 3; d++)
      chk(d, "post_reset2", 3'b111, 3'b000);
    ticks(3);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations pending, required 0",
               q.size());
      n_bad += q.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
